// File: rtl/jtag_uart_port_arbiter_if.sv
// Avalon-MM master bundle between the port arbiter and the JTAG UART slave.
// The data register is the only target, so the address is a single bit.
interface jtag_uart_port_arbiter_if;
   logic        avm_chipselect;
   logic        avm_address;
   logic        avm_read_n;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   modport master (
      output avm_chipselect,
      output avm_address,
      output avm_read_n,
      output avm_write_n,
      output avm_writedata,
      input  avm_readdata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_chipselect,
      input  avm_address,
      input  avm_read_n,
      input  avm_write_n,
      input  avm_writedata,
      output avm_readdata,
      output avm_waitrequest
   );
endinterface

// File: rtl/jtag_uart_port_arbiter.sv
// Shares the JTAG UART data register between a read requester and a write requester,
// one transaction at a time, with fair alternation and a waitrequest timeout.
module jtag_uart_port_arbiter #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        rd_req,
   output logic        rd_done,
   output logic [7:0]  rd_data,
   output logic        rd_valid,

   input  logic        wr_req,
   input  logic [7:0]  wr_data,
   output logic        wr_done,

   output logic        timeout_err,
   output logic [7:0]  err_count,
   output logic        busy,

   jtag_uart_port_arbiter_if.master bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   localparam bit             TIMEOUT_EN  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic [1:0]       state;
   logic             last_grant;
   logic [CNT_W-1:0] wait_cnt;

   logic grant_rd;
   logic grant_wr;
   logic wait_expired;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      grant_rd     = 1'b0;
      grant_wr     = 1'b0;
      wait_expired = 1'b0;
      if (rd_req && (!wr_req || last_grant == GRANT_WR)) grant_rd = 1'b1;
      if (wr_req && (!rd_req || last_grant == GRANT_RD)) grant_wr = 1'b1;
      if (TIMEOUT_EN && wait_cnt == TIMEOUT_CNT)        wait_expired = 1'b1;
   end

   assign bus.avm_address = 1'b0;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= ST_IDLE;
         last_grant         <= GRANT_WR;
         wait_cnt           <= '0;
         busy               <= 1'b0;
         rd_done            <= 1'b0;
         wr_done            <= 1'b0;
         timeout_err        <= 1'b0;
         rd_data            <= 8'h00;
         rd_valid           <= 1'b0;
         err_count          <= 8'h00;
         bus.avm_chipselect <= 1'b0;
         bus.avm_read_n     <= 1'b1;
         bus.avm_write_n    <= 1'b1;
         bus.avm_writedata  <= 32'h0;
      end else begin
         rd_done            <= 1'b0;
         wr_done            <= 1'b0;
         timeout_err        <= 1'b0;
         bus.avm_chipselect <= 1'b1;

         case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (grant_rd) begin
                  state          <= ST_RD;
                  busy           <= 1'b1;
                  last_grant     <= GRANT_RD;
                  bus.avm_read_n <= 1'b0;
               end else if (grant_wr) begin
                  state             <= ST_WR;
                  busy              <= 1'b1;
                  last_grant        <= GRANT_WR;
                  bus.avm_write_n   <= 1'b0;
                  bus.avm_writedata <= {24'h0, wr_data};
               end
            end

            ST_RD, ST_WR: begin
               if (!bus.avm_waitrequest) begin
                  state           <= ST_IDLE;
                  busy            <= 1'b0;
                  bus.avm_read_n  <= 1'b1;
                  bus.avm_write_n <= 1'b1;
                  if (state == ST_RD) begin
                     rd_done  <= 1'b1;
                     rd_data  <= bus.avm_readdata[7:0];
                     rd_valid <= bus.avm_readdata[15];
                  end else begin
                     wr_done <= 1'b1;
                  end
               end else if (wait_expired) begin
                  // Abort: the requester gets timeout_err instead of a done pulse,
                  // and captured read data stays as it was.
                  state           <= ST_IDLE;
                  busy            <= 1'b0;
                  bus.avm_read_n  <= 1'b1;
                  bus.avm_write_n <= 1'b1;
                  timeout_err     <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: begin
               state           <= ST_IDLE;
               busy            <= 1'b0;
               bus.avm_read_n  <= 1'b1;
               bus.avm_write_n <= 1'b1;
            end
         endcase
      end
   end

   a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
      bus.avm_read_n || bus.avm_write_n);

   a_pulses_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0({rd_done, wr_done, timeout_err}));

   a_busy_tracks_state: assert property (@(posedge clk) disable iff (!reset_n)
      busy == (state != ST_IDLE));

endmodule

// File: tb/tb_jtag_uart_port_arbiter.sv
// Directed bench for jtag_uart_port_arbiter: single reads/writes, stalls, contention,
// timeout and asynchronous reset in the middle of a read.
module tb_jtag_uart_port_arbiter;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       rd_req;
   logic       rd_done;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       wr_req;
   logic [7:0] wr_data;
   logic       wr_done;
   logic       timeout_err;
   logic [7:0] err_count;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat;

   jtag_uart_port_arbiter_if bus ();

   jtag_uart_port_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_req      (rd_req),
      .rd_done     (rd_done),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .wr_req      (wr_req),
      .wr_data     (wr_data),
      .wr_done     (wr_done),
      .timeout_err (timeout_err),
      .err_count   (err_count),
      .busy        (busy),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it to its done or timeout pulse.
   // The slave stalls for the first `stalls` cycles the strobe is low.
   task automatic run_txn(input bit is_wr, input logic [7:0] data, input int stalls,
                          output int strobe_cyc, output int other_low, output int done_cnt,
                          output int to_cnt, output int wd_bad, output int lat);
      bit strobe, other, mine_done;
      strobe_cyc = 0; other_low = 0; done_cnt = 0; to_cnt = 0; wd_bad = 0; lat = -1;
      bus.avm_waitrequest = 1'b0;
      if (is_wr) begin
         wr_data = data;
         wr_req  = 1'b1;
      end else begin
         rd_req = 1'b1;
      end
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         strobe    = is_wr ? !bus.avm_write_n : !bus.avm_read_n;
         other     = is_wr ? !bus.avm_read_n  : !bus.avm_write_n;
         mine_done = is_wr ? wr_done : rd_done;
         if (strobe) begin
            strobe_cyc++;
            if (is_wr) begin
               if (bus.avm_writedata !== {24'h0, data}) wd_bad++;
               wr_data = ~data;
            end
         end
         if (other)       other_low++;
         if (mine_done)   done_cnt++;
         if (timeout_err) to_cnt++;
         bus.avm_waitrequest = strobe && (strobe_cyc <= stalls);
         if (mine_done || timeout_err) begin
            lat    = cyc;
            rd_req = 1'b0;
            wr_req = 1'b0;
            break;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      if (is_wr ? wr_done : rd_done) done_cnt++;
      if (timeout_err)               to_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int        grants, gap, gaps_bad, overlap, rdn, wrn;
      bit        cur, prev;
      logic [3:0] order;

      reset_n             = 1'b0;
      rd_req              = 1'b0;
      wr_req              = 1'b0;
      wr_data             = 8'h00;
      bus.avm_readdata    = 32'h0;
      bus.avm_waitrequest = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_read_n",     bus.avm_read_n,     1);
      check("rst_write_n",    bus.avm_write_n,    1);
      check("rst_writedata",  bus.avm_writedata,  0);
      check("rst_chipselect", bus.avm_chipselect, 0);
      check("rst_address",    bus.avm_address,    0);
      check("rst_pulses",     {rd_done, wr_done, timeout_err}, 0);
      check("rst_rd_data",    {rd_valid, rd_data}, 0);
      check("rst_err_count",  err_count, 0);
      check("rst_busy",       busy, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("chipselect_on", bus.avm_chipselect, 1);
      check("idle_busy",     busy, 0);

      // Zero-wait read with RVALID set.
      bus.avm_readdata = 32'h0000_8083;
      run_txn(1'b0, 8'h00, 0, s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat);
      check("rd1_strobe_cycles", s_cyc, 1);
      check("rd1_other_strobe",  s_other, 0);
      check("rd1_done_pulses",   s_done, 1);
      check("rd1_timeouts",      s_to, 0);
      check("rd1_latency",       s_lat, 2);
      check("rd1_data",          rd_data, 8'h83);
      check("rd1_valid",         rd_valid, 1);

      // Write stalled for 3 cycles; wr_data changes after grant must be ignored.
      run_txn(1'b1, 8'hE5, 3, s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat);
      check("wr1_strobe_cycles", s_cyc, 4);
      check("wr1_writedata_bad", s_wd_bad, 0);
      check("wr1_other_strobe",  s_other, 0);
      check("wr1_done_pulses",   s_done, 1);
      check("wr1_timeouts",      s_to, 0);
      check("wr1_latency",       s_lat, 5);

      // Contention: last grant was WR, so order is RD, WR, RD, WR.
      bus.avm_readdata    = 32'h0000_80C1;
      bus.avm_waitrequest = 1'b0;
      wr_data = 8'h5A;
      rd_req  = 1'b1;
      wr_req  = 1'b1;
      grants = 0; gap = 0; gaps_bad = 0; overlap = 0; rdn = 0; wrn = 0;
      prev = 1'b0; order = 4'h0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (!bus.avm_read_n && !bus.avm_write_n) overlap++;
         cur = !bus.avm_read_n || !bus.avm_write_n;
         if (cur && !prev) begin
            if (grants < 4) order[grants] = !bus.avm_write_n;
            if (grants > 0 && gap != 1) gaps_bad++;
            grants++;
            gap = 0;
         end
         if (!cur) gap++;
         if (rd_done) rdn++;
         if (wr_done) wrn++;
         prev = cur;
         if (rdn + wrn >= 4) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
            break;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      @(negedge clk);
      check("mix_grant_order", order, 4'b1010);
      check("mix_grants",      grants, 4);
      check("mix_idle_gaps",   gaps_bad, 0);
      check("mix_overlap",     overlap, 0);
      check("mix_rd_done",     rdn, 2);
      check("mix_wr_done",     wrn, 2);
      check("mix_busy_after",  busy, 0);

      // Read with RVALID clear: data still captured.
      bus.avm_readdata = 32'h0000_0041;
      run_txn(1'b0, 8'h00, 0, s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat);
      check("rd2_done_pulses", s_done, 1);
      check("rd2_latency",     s_lat, 2);
      check("rd2_data",        rd_data, 8'h41);
      check("rd2_valid",       rd_valid, 0);

      // Write stuck in waitrequest: 8 counted wait edges, abort on the 9th.
      run_txn(1'b1, 8'h3C, 1000, s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat);
      check("to_strobe_cycles", s_cyc, 9);
      check("to_pulses",        s_to, 1);
      check("to_done_pulses",   s_done, 0);
      check("to_latency",       s_lat, 10);
      check("to_err_count",     err_count, 1);
      check("to_rd_data_kept",  {rd_valid, rd_data}, {1'b0, 8'h41});
      check("to_busy_after",    busy, 0);

      // Asynchronous reset in the middle of a stalled read.
      bus.avm_readdata    = 32'h0000_80FF;
      bus.avm_waitrequest = 1'b1;
      rd_req = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rd_strobe", bus.avm_read_n, 0);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_read_n",     bus.avm_read_n, 1);
      check("mid_rst_busy",       busy, 0);
      check("mid_rst_chipselect", bus.avm_chipselect, 0);
      check("mid_rst_err_count",  err_count, 0);
      rd_req = 1'b0;
      @(negedge clk);
      check("mid_rst_no_done", rd_done, 0);
      reset_n = 1'b1;
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      bus.avm_readdata = 32'h0000_80AA;
      run_txn(1'b0, 8'h00, 0, s_cyc, s_other, s_done, s_to, s_wd_bad, s_lat);
      check("rd3_strobe_cycles", s_cyc, 1);
      check("rd3_done_pulses",   s_done, 1);
      check("rd3_latency",       s_lat, 2);
      check("rd3_data",          rd_data, 8'hAA);
      check("rd3_valid",         rd_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_uart_port_arbiter.md
Name: jtag_uart_port_arbiter

Overview:
- Shares the single JTAG UART Avalon slave between two requesters: the command/pulse-value receive path (read side) and the sample-upload transmit path (write side).
- Runs one bus transaction at a time. Alternates grants fairly when both sides request, and returns per-transaction completion pulses with the received byte and its RVALID flag.
- Aborts a transaction held too long by waitrequest and counts those timeouts.
- Sits between the main sequencing FSM and the uart_jtag instance, replacing ad-hoc direct read/write strobes.

Parameters:
- TIMEOUT, 1024: max consecutive waitrequest-high cycles per transaction; 0 disables the timeout.
- CNT_W, 11: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- rd_req  in  1  read requester wants one data-register read (level).
- rd_done  out  1  one-cycle pulse: read transaction finished.
- rd_data  out  8  readdata[7:0] captured at completion; held until the next rd_done.
- rd_valid  out  1  readdata[15] (RVALID) captured at completion; held like rd_data.
- wr_req  in  1  write requester wants one byte sent (level).
- wr_data  in  8  byte to send; sampled at grant.
- wr_done  out  1  one-cycle pulse: write transaction finished.
- timeout_err  out  1  one-cycle pulse: active transaction aborted by timeout.
- err_count  out  8  saturating count of timeouts.
- busy  out  1  high whenever state is not IDLE.
- avm_chipselect  out  1  constant 1 out of reset; 0 in reset.
- avm_address  out  1  constant 0 (data register).
- avm_read_n  out  1  active-low read strobe.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  {24'b0, captured byte}.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, reset_n=0) drives:
  - state=IDLE, avm_read_n=1, avm_write_n=1, avm_writedata=0, avm_chipselect=0.
  - rd_done, wr_done and timeout_err = 0; rd_data=0, rd_valid=0, err_count=0, busy=0.
  - last_grant=WR, so the first contested grant goes to the read side.
- Reset mid-transaction drops the strobes immediately and discards the transaction; no done pulse is issued.
- All outputs are registered.
- IDLE:
  - Only rd_req alone → RD.
  - Only wr_req alone → WR; latch wr_data.
  - Both high → grant the side opposite last_grant.
  - Update last_grant at grant time. Clear wait_cnt.
- RD: avm_read_n=0 from the cycle after the grant edge.
  - At an edge with avm_waitrequest=0: capture rd_data=avm_readdata[7:0] and rd_valid=avm_readdata[15].
  - Same edge: pulse rd_done, set avm_read_n=1, go to IDLE.
- WR: avm_write_n=0 and avm_writedata={24'b0, latched byte}.
  - At an edge with avm_waitrequest=0: pulse wr_done, set avm_write_n=1, go to IDLE.
- Timeout (TIMEOUT>0): in RD/WR, wait_cnt increments on each edge with waitrequest=1.
  - When wait_cnt==TIMEOUT and waitrequest is still 1: release the strobe, pulse timeout_err, and go to IDLE.
  - err_count increments, saturating at 255.
  - No rd_done/wr_done pulse; rd_data and rd_valid are unchanged.
- Latency:
  - Request seen at edge N → strobe active in cycle N+1.
  - Zero-wait completion at edge N+1 → done pulse during cycle N+2.
  - Minimum 2 cycles per transaction plus 1 IDLE cycle between transactions.
- Requester rule: hold req until the done pulse (or timeout_err). A req still high in the cycle after done counts as a new request. wr_data changes after grant are ignored.
- rd_valid=0 on a completed read means the UART FIFO was empty; rd_data is still updated and rd_done still pulses.
- Exactly one strobe is active at a time; read and write strobes are never low simultaneously.
- Done pulses and timeout_err are mutually exclusive.

Test Plan:
- Reset then rd_req=1 with waitrequest=0 and readdata=0x0000_8083 → avm_read_n low for exactly 1 cycle; rd_done pulses 2 cycles after the request edge; rd_data=0x83, rd_valid=1.
- wr_req=1, wr_data=0xE5, waitrequest high 3 cycles → avm_write_n low for 4 cycles with writedata=0x0000_00E5; wr_done pulses once.
- rd_req and wr_req held high together for 4 transactions → grant order RD, WR, RD, WR; never both strobes low; one IDLE cycle between transactions.
- TIMEOUT=8, waitrequest stuck high on a write → strobe released after 8 wait cycles; timeout_err pulses; err_count=1; no wr_done.
- Read with readdata=0x0000_0041 (RVALID=0) → rd_done pulses; rd_valid=0; rd_data=0x41.
- reset_n low mid-RD with waitrequest high → avm_read_n=1 immediately; no rd_done; after release the next request starts cleanly from IDLE.
